// File: rtl/queue_burst_reader_if.sv
// Bus bundle between the burst reader, the circular queue it reads and the byte sink.
// The master side belongs to the reader; the slave side to the queue/sink.
interface queue_burst_reader_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          q_en;
  logic [AW-1:0] q_read;
  logic [DW-1:0] q_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport master (
    output q_en, q_read, m_data, m_valid, m_last,
    input  q_data, m_ready
  );

  modport slave (
    input  q_en, q_read, m_data, m_valid, m_last,
    output q_data, m_ready
  );
endinterface

// File: rtl/queue_burst_reader.sv
// Walks a 16-entry queue from a start index with wrap-around and streams the
// returned bytes out over valid/ready with a last flag and a running checksum.
module queue_burst_reader #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        start_idx,
  input  logic [AW:0]          len,
  output logic                 busy,
  output logic                 done,
  output logic [DW-1:0]        sum,
  queue_burst_reader_if.master bus
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] start_idx_q, start_idx_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   issue_q, issue_d;
  logic [AW:0]   dlv_q, dlv_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] q_read_q, q_read_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  logic          fifo_valid, pop, push, accept, issue, head_last;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   len_clamped;

  assign fifo_valid  = (count_q != 2'd0);
  assign pop         = fifo_valid & bus.m_ready;
  assign push        = inflight_q;
  assign head_last   = ((dlv_q + (AW+1)'(1)) == len_q);
  assign accept      = (state_q == IDLE) && start;
  assign rd_idx      = start_idx_q + issue_q[AW-1:0];
  assign len_clamped = (len > DEPTH) ? DEPTH : len;
  // Buffered bytes plus the read still in flight must leave room in the
  // 2-entry FIFO once this cycle's pop is accounted for.
  assign issue = (state_q == RUN) &&
                 (({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
      RUN:     if (issue && ((issue_q + (AW+1)'(1)) == len_q)) state_d = DRAIN;
      DRAIN:   if (pop && head_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN) || (state_q == DRAIN);
    done        = (state_q == DONE);
    sum         = sum_q;
    bus.q_en    = issue;
    bus.q_read  = issue ? rd_idx : q_read_q;
    bus.m_valid = fifo_valid;
    bus.m_data  = mem_q[rd_ptr_q];
    bus.m_last  = fifo_valid & head_last;
  end

  always_comb begin
    start_idx_d = start_idx_q;
    len_d       = len_q;
    issue_d     = issue_q;
    dlv_d       = dlv_q;
    q_read_d    = q_read_q;
    sum_d       = sum_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = issue;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};

    if (accept) begin
      start_idx_d = start_idx;
      len_d       = len_clamped;
      issue_d     = '0;
      dlv_d       = '0;
      sum_d       = '0;
    end
    if (issue) begin
      issue_d  = issue_q + (AW+1)'(1);
      q_read_d = rd_idx;
    end
    // Queue data arrives one cycle after the request, so capture follows q_en.
    if (push) begin
      mem_d[wr_ptr_q] = bus.q_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      dlv_d    = dlv_q + (AW+1)'(1);
      sum_d    = sum_q + mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_idx_q <= '0;
      len_q       <= '0;
      issue_q     <= '0;
      dlv_q       <= '0;
      inflight_q  <= 1'b0;
      q_read_q    <= '0;
      sum_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      start_idx_q <= start_idx_d;
      len_q       <= len_d;
      issue_q     <= issue_d;
      dlv_q       <= dlv_d;
      inflight_q  <= inflight_d;
      q_read_q    <= q_read_d;
      sum_q       <= sum_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: doc/queue_burst_reader.md
# queue_burst_reader

Downstream consumer of the 16-entry, 8-bit circular queue. On a start command it walks the queue's read index from a start position for a given length, with wrap-around. It captures each byte the queue returns and streams the bytes out over a valid/ready interface with a last flag and a running modulo-256 checksum. It drives the queue's `en`/`read` inputs and takes the queue's `dataout`.

## Interface
- `DW`, 8, data width; matches queue `datain`/`dataout`.
- `AW`, 4, queue index width; depth is 2^AW = 16.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  burst request; sampled only in IDLE.
- `start_idx`  in  AW  first queue index to read.
- `len`  in  AW+1  byte count; 0 = empty burst; values >16 are clamped to 16.
- `busy`  out  1  high from accepted start until the cycle before `done`.
- `done`  out  1  one-cycle pulse when the burst has completed.
- `q_en`  out  1  to queue `en`; qualifies a read request.
- `q_read`  out  AW  to queue `read`; index being requested.
- `q_data`  in  DW  from queue `dataout`; valid exactly 1 cycle after the `q_en` cycle.
- `m_data`  out  DW  output byte.
- `m_valid`  out  1  output byte valid.
- `m_ready`  in  1  sink accepts the byte.
- `m_last`  out  1  high with the final byte of the burst.
- `sum`  out  DW  modulo-256 sum of the bytes handed off in the current or most recent burst.

## Operation
- FSM states:
  - IDLE: `start` goes to RUN; with `len`=0 it goes to DONE instead.
  - RUN: issues reads.
  - DRAIN: all reads issued; waits for the output to empty.
  - DONE: one cycle, then back to IDLE.
- On start accept:
  - Latch `start_idx`, clamped `len`.
  - Clear `sum`.
  - Clear the issue counter and the delivered counter.
- Read issue:
  - `q_read` = (`start_idx` + k) mod 16 for k = 0..len-1. Wrap from 15 to 0 is natural AW-bit overflow.
  - A read is issued only when (output buffer occupancy + reads in flight − pop this cycle) < 2.
  - Output buffer is a 2-entry FIFO. It is never overrun and never drops a byte.
  - When issue count reaches len, RUN goes to DRAIN.
- Capture: `q_data` is written into the FIFO in the cycle after each `q_en` cycle.
- Output:
  - `m_valid` = FIFO non-empty; `m_data` = FIFO head.
  - A handshake is `m_valid & m_ready`.
  - While `m_valid` is high and `m_ready` is low, `m_data`/`m_last` are held stable.
- `m_last`: high when the head byte is the len-th byte of the burst.
- `sum`: on every handshake, `sum` ← `sum` + `m_data`, truncated to DW bits. It holds after `done` until the next start accept.
- Bytes are delivered in index order, exactly len of them, each index read exactly once. A 16-byte burst touches all entries once.
- `start` while not IDLE is ignored, with no effect on the burst in progress.
- `q_en` is low whenever no read is issued. `q_read` holds its last value when idle.

## Timing
- Reset value of every output is 0. `rst` clears the FSM to IDLE, empties the FIFO, and clears in-flight state immediately (asynchronous). A burst interrupted by reset is abandoned with no `done`.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in IDLE.
- First `q_en` is in cycle 1. First `q_data` is valid in cycle 2. First `m_valid` is in cycle 3.
- With `m_ready` held at 1:
  - Throughput is 1 byte/cycle.
  - `q_en` is high in cycles 1..len.
  - `m_valid` is high in cycles 3..len+2.
  - `m_last` is in cycle len+2.
  - `done` is in cycle len+3, and `busy` falls in that cycle.
- `len`=0: `busy` is never set, `done` is in cycle 1, there is no `q_en` or `m_valid`, and `sum`=0.
- `busy` is high from cycle 1 through the cycle of the last handshake.
- A new `start` is accepted in the cycle after `done` at the earliest.

## Test plan
Queue model preloaded 0..15 = 80,40,20,10,08,04,02,01,C0,A0,90,88,84,82,81,E0 (hex), 1-cycle read latency.

- Basic burst: `start_idx`=3, `len`=4, `m_ready`=1.
  - `q_read` = 3,4,5,6 in cycles 1–4.
  - `m_data` = 10,08,04,02 in cycles 3–6; `m_last` with 02.
  - `sum`=1E; `done` in cycle 7.
- Wrap-around: `start_idx`=14, `len`=4 → reads 14,15,0,1; `m_data` = 81,E0,80,40; `sum`=21.
- Backpressure: `start_idx`=0, `len`=3, `m_ready`=0 in cycles 3–6, then 1.
  - `m_data` held at 80 with `m_valid` high.
  - No more than 2 reads outstanding or buffered (`q_en` stops after index 1).
  - Then 80,40,20 are delivered in order; `m_last` with 20.
- Full/empty lengths:
  - `start_idx`=5, `len`=16: 16 bytes from idx 5 through 4, each once; `sum`=DE.
  - `len`=0: `done` in cycle 1, no `m_valid`, `sum`=0.
  - `len`=20: behaves as 16.
- Reset and collisions:
  - Assert `rst` during cycle 4 of a `len`=8 burst: all outputs are 0 immediately, no `done`.
  - A `start` pulse during a busy burst is ignored; the burst completes unchanged.
